// File: rtl/pc_fetch_seq_pkg.sv
// Shared types and constants for the PC fetch sequencer.
// Covers redirect-source and FSM-state enums, the reset vector and target selection.
package fetch_pkg;

  typedef enum logic [2:0] {
    NONE   = 3'd0,
    JALR   = 3'd1,
    BRANCH = 3'd2,
    JAL    = 3'd3,
    MTVEC  = 3'd4,
    MEPC   = 3'd5
  } pc_src_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam int          INSTR_BYTES          = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } redirect_t;

  // Codes 0/6/7 come back with valid=0 so the redirect is ignored.
  function automatic redirect_t select_target(
    input logic [2:0]  src,
    input logic [31:0] jal,
    input logic [31:0] branch,
    input logic [31:0] jalr,
    input logic [31:0] mtvec,
    input logic [31:0] mepc
  );
    redirect_t r;
    r.valid = 1'b1;
    r.addr  = '0;
    case (src)
      JALR:    r.addr = {jalr[31:1], 1'b0};
      BRANCH:  r.addr = branch;
      JAL:     r.addr = jal;
      MTVEC:   r.addr = mtvec;
      MEPC:    r.addr = mepc;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pc_fetch_seq_if.sv
// Instruction-memory req/gnt/rvalid bus. The fetch sequencer is the master.
interface pc_fetch_seq_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/pc_fetch_seq_fetch_buf.sv
// Two-entry response FIFO holding {pc, instr}; flush empties it in one cycle.
// The caller guarantees no push when full and no pop when empty.
module fetch_buf #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr, rd_ptr;

  always_ff @(posedge clk)
    if (push && !flush) mem[wr_ptr] <= din;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/pc_fetch_seq.sv
// Front-end fetch sequencer: owns the PC, issues IMEM fetches, kills in-flight work on redirect.
// Build option FETCH_BUF_EN adds a 2-entry response FIFO and allows 2 outstanding fetches.
module pc_fetch_seq
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR    = DEFAULT_RESET_VECTOR,
  parameter int          MAX_OUTSTANDING = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect,
  input  logic [2:0]            pc_source,
  input  logic [31:0]           jal,
  input  logic [31:0]           branch,
  input  logic [31:0]           jalr,
  input  logic [31:0]           mtvec,
  input  logic [31:0]           mepc,
  pc_fetch_seq_if.master        imem,
  output logic [31:0]           ir,
  output logic [31:0]           ir_pc,
  output logic                  ir_valid,
  input  logic                  ir_ready,
  output logic [31:0]           pc,
  output logic                  misalign,
  output logic [31:0]           misalign_addr
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q;
  logic [1:0]   out_q, kill_q, out_next;
  logic [31:0]  tag_q [2];
  logic         tag_wr_q, tag_rd_q;
  logic [31:0]  tag_head;

  redirect_t    rd;
  logic         take_redir, aligned;
  logic         gnt_fire, rsp_fire, rsp_live, ir_free, can_issue;
  logic         load_ir;
  logic [31:0]  load_pc, load_instr;

  assign rd         = select_target(pc_source, jal, branch, jalr, mtvec, mepc);
  assign take_redir = redirect && rd.valid;
  assign aligned    = (rd.addr[1:0] == 2'b00);

  assign gnt_fire = imem.req && imem.gnt;
  // Responses with nothing outstanding (e.g. stragglers across a reset) are ignored.
  assign rsp_fire = imem.rvalid && (out_q != 2'd0);
  assign rsp_live = rsp_fire && (kill_q == 2'd0) && !take_redir;
  assign ir_free  = !ir_valid || ir_ready;
  assign out_next = out_q + {1'b0, gnt_fire} - {1'b0, rsp_fire};
  assign tag_head = tag_q[tag_rd_q];

`ifdef FETCH_BUF_EN
  logic [1:0]  fifo_cnt;
  logic [63:0] fifo_head;
  logic        fifo_push, fifo_pop, load_bypass;

  // FIFO entries plus outstanding fetches may never exceed the two buffer slots.
  assign can_issue   = ({1'b0, out_q} + {1'b0, fifo_cnt}) < 3'd2;
  assign load_bypass = rsp_live && (fifo_cnt == 2'd0) && ir_free;
  assign fifo_pop    = (fifo_cnt != 2'd0) && ir_free && !take_redir;
  assign fifo_push   = rsp_live && !load_bypass;
  assign load_ir     = fifo_pop || load_bypass;
  assign load_pc     = (fifo_cnt != 2'd0) ? fifo_head[63:32] : tag_head;
  assign load_instr  = (fifo_cnt != 2'd0) ? fifo_head[31:0]  : imem.rdata;

  fetch_buf #(.W(64)) u_fetch_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (take_redir),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({tag_head, imem.rdata}),
    .head  (fifo_head),
    .count (fifo_cnt)
  );
`else
  localparam logic [1:0] MAX_OUT = 2'(MAX_OUTSTANDING);

  // A single IR slot and no buffer: only one response may be headed for it.
  assign can_issue  = (out_q < MAX_OUT) && (out_q == 2'd0) && ir_free;
  assign load_ir    = rsp_live;
  assign load_pc    = tag_head;
  assign load_instr = imem.rdata;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d  = state_q;
    imem.req = 1'b0;
    case (state_q)
      IDLE:    state_d = ISSUE;
      ISSUE:   imem.req = can_issue;
      FAULT:   imem.req = 1'b0;
      default: state_d = IDLE;
    endcase
    if (take_redir) state_d = aligned ? ISSUE : FAULT;
  end

  // pc_q only moves on a grant, so addr stays put while a request waits for gnt.
  assign imem.addr = pc_q;
  assign pc        = pc_q;

  always_ff @(posedge clk)
    if (gnt_fire) tag_q[tag_wr_q] <= pc_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_q          <= RESET_VECTOR;
      out_q         <= 2'd0;
      kill_q        <= 2'd0;
      tag_wr_q      <= 1'b0;
      tag_rd_q      <= 1'b0;
      misalign      <= 1'b0;
      misalign_addr <= 32'h0;
    end else begin
      out_q <= out_next;
      if (gnt_fire) tag_wr_q <= ~tag_wr_q;
      if (rsp_fire) tag_rd_q <= ~tag_rd_q;

      if (take_redir && aligned) pc_q <= rd.addr;
      else if (gnt_fire)         pc_q <= pc_q + 32'(INSTR_BYTES);

      // Everything still in flight after this edge, including a same-cycle grant, is dead.
      if (take_redir)                           kill_q <= out_next;
      else if (rsp_fire && (kill_q != 2'd0))    kill_q <= kill_q - 2'd1;

      if (take_redir) begin
        misalign <= !aligned;
        if (!aligned) misalign_addr <= rd.addr;
      end
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ir       <= 32'h0;
      ir_pc    <= 32'h0;
      ir_valid <= 1'b0;
    end else if (take_redir) begin
      ir_valid <= 1'b0;
    end else if (load_ir) begin
      ir       <= load_instr;
      ir_pc    <= load_pc;
      ir_valid <= 1'b1;
    end else if (ir_valid && ir_ready) begin
      ir_valid <= 1'b0;
    end

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Scoreboard bench for pc_fetch_seq: expected fetch addresses and IR handoffs are queued by
// the stimulus, and independent monitors pop and compare them as the DUT presents them.
module tb_pc_fetch_seq;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [2:0]  pc_source = 3'd0;
  logic [31:0] jal = '0, branch = '0, jalr = '0, mtvec = '0, mepc = '0;
  logic        ir_ready = 1'b1;
  logic [31:0] ir, ir_pc, pc, misalign_addr;
  logic        ir_valid, misalign;

  always #5 clk = ~clk;

  pc_fetch_seq_if imem ();

  pc_fetch_seq dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect      (redirect),
    .pc_source     (pc_source),
    .jal           (jal),
    .branch        (branch),
    .jalr          (jalr),
    .mtvec         (mtvec),
    .mepc          (mepc),
    .imem          (imem),
    .ir            (ir),
    .ir_pc         (ir_pc),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready),
    .pc            (pc),
    .misalign      (misalign),
    .misalign_addr (misalign_addr)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int budget = 0;
  int rsp_delay = 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic [31:0] exp_addr_q [$];
  logic [63:0] exp_ir_q [$];
  pend_t       pend_q [$];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  // IMEM model: grants while budget lasts, answers in order after rsp_delay cycles.
  initial begin
    imem.gnt = 1'b0;
    imem.rvalid = 1'b0;
    imem.rdata = '0;
    forever begin
      @(negedge clk); #1;
      imem.rvalid = 1'b0;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        imem.rvalid = 1'b1;
        imem.rdata  = instr_of(pend_q[0].addr);
        void'(pend_q.pop_front());
      end
      imem.gnt = imem.req && (budget > 0);
      if (imem.gnt) begin
        budget--;
        pend_q.push_back('{imem.addr, cyc + rsp_delay});
      end
    end
  end

  initial begin : mon_addr
    logic [31:0] ea;
    forever begin
      @(negedge clk); #2;
      if (imem.req && imem.gnt) begin
        if (exp_addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL addr unexpected grant got %h", imem.addr);
        end else begin
          ea = exp_addr_q.pop_front();
          chk("imem_addr", imem.addr, ea);
        end
      end
    end
  end

  initial begin : mon_ir
    logic [63:0] ei;
    forever begin
      @(negedge clk); #2;
      if (ir_valid && ir_ready) begin
        if (exp_ir_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ir unexpected handoff got pc %h instr %h", ir_pc, ir);
        end else begin
          ei = exp_ir_q.pop_front();
          chk("ir_pc", ir_pc, ei[63:32]);
          chk("ir", ir, ei[31:0]);
        end
      end
    end
  end

  task automatic exp_ir(input logic [31:0] p, input logic [31:0] i);
    exp_ir_q.push_back({p, i});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_addr_q.size() != 0 || exp_ir_q.size() != 0 || pend_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s drain timeout got addr_left %0d ir_left %0d want 0", name,
               exp_addr_q.size(), exp_ir_q.size());
      exp_addr_q.delete();
      exp_ir_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_redirect(input logic [2:0] src, input logic [31:0] tgt);
    pc_source = src;
    case (src)
      3'd1:    jalr   = tgt;
      3'd2:    branch = tgt;
      3'd3:    jal    = tgt;
      3'd4:    mtvec  = tgt;
      default: mepc   = tgt;
    endcase
    redirect = 1'b1;
    @(negedge clk);
    redirect  = 1'b0;
    pc_source = 3'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem.req), 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_ir_pc", ir_pc, 32'h0);
    chk("rst_ir_valid", 32'(ir_valid), 32'h0);
    chk("rst_misalign", 32'(misalign), 32'h0);
    chk("rst_misalign_addr", misalign_addr, 32'h0);

    // Sequential fetch from the reset vector
    rst_n = 1'b1;
    chk("idle_req", 32'(imem.req), 32'h0);
    @(negedge clk);
    chk("first_req", 32'(imem.req), 32'h1);
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_ir(32'h0, 32'h0000_0013);
    exp_ir(32'h4, 32'h0000_0413);
    budget = 2;
    drain("seq");
    chk("pc_after_seq", pc, 32'h8);

    // JAL redirect while the 0x8 fetch is outstanding: its response must be dropped
    rsp_delay = 4;
    exp_addr_q.push_back(32'h8);
    exp_addr_q.push_back(32'h100);
    exp_ir(32'h100, 32'h0001_0013);
    budget = 2;
    repeat (2) @(negedge clk);
    do_redirect(3'd3, 32'h100);
    drain("kill");
    rsp_delay = 1;

    // JALR clears bit 0
    exp_addr_q.push_back(32'h204);
    exp_ir(32'h204, 32'h0002_0413);
    do_redirect(3'd1, 32'h205);
    chk("jalr_misalign", 32'(misalign), 32'h0);
    budget = 1;
    drain("jalr");

    // Misaligned branch target halts fetch until an aligned redirect
    do_redirect(3'd2, 32'h206);
    chk("fault_misalign", 32'(misalign), 32'h1);
    chk("fault_addr", misalign_addr, 32'h206);
    chk("fault_pc_kept", pc, 32'h208);
    budget = 1;
    repeat (3) begin
      chk("fault_req", 32'(imem.req), 32'h0);
      @(negedge clk);
    end
    exp_addr_q.push_back(32'h80);
    exp_ir(32'h80, 32'h0000_8013);
    do_redirect(3'd4, 32'h80);
    chk("mtvec_misalign", 32'(misalign), 32'h0);
    drain("mtvec");

    // Decode stall: no new request, IR held
    ir_ready = 1'b0;
    exp_addr_q.push_back(32'h84);
    exp_ir(32'h84, 32'h0000_8413);
    budget = 1;
    for (int i = 0; i < 20 && !ir_valid; i++) @(negedge clk);
    chk("stall_fill", 32'(ir_valid), 32'h1);
    budget = 1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_req", 32'(imem.req), 32'h0);
      chk("stall_ir", ir, 32'h0000_8413);
      chk("stall_ir_pc", ir_pc, 32'h84);
      chk("stall_valid", 32'(ir_valid), 32'h1);
    end
    exp_addr_q.push_back(32'h88);
    exp_ir(32'h88, 32'h0000_8813);
    ir_ready = 1'b1;
    drain("stall");

    // PC wrap at the top of the address space
    exp_addr_q.push_back(32'hFFFF_FFFC);
    exp_addr_q.push_back(32'h0);
    exp_ir(32'hFFFF_FFFC, 32'hFFFF_FC13);
    exp_ir(32'h0, 32'h0000_0013);
    do_redirect(3'd3, 32'hFFFF_FFFC);
    budget = 2;
    drain("wrap");
    chk("wrap_pc", pc, 32'h4);

    // Reserved source code: redirect ignored
    do_redirect(3'd6, 32'h0000_0301);
    chk("ignored_pc", pc, 32'h4);
    chk("ignored_misalign", 32'(misalign), 32'h0);

    // Reset with a response pending; the late response must not reach IR
    rsp_delay = 6;
    exp_addr_q.push_back(32'h4);
    budget = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #3;
    chk("rst2_req", 32'(imem.req), 32'h0);
    chk("rst2_pc", pc, 32'h0);
    chk("rst2_ir", ir, 32'h0);
    chk("rst2_ir_pc", ir_pc, 32'h0);
    chk("rst2_ir_valid", 32'(ir_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("late_rsp_valid", 32'(ir_valid), 32'h0);
    chk("late_rsp_delivered", 32'(pend_q.size()), 32'h0);
    chk("late_addr_seen", 32'(exp_addr_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
